// File: rtl/stack_unit_pkg.sv
// Shared stack-unit constants: operation codes driven by the control unit
// on sigNewSP, plus default geometry of the stack.
package stack_unit_pkg;

   localparam int STACK_DATA_W = 16;
   localparam int STACK_DEPTH  = 8;

   typedef enum logic [1:0] {
      stackPointerDef  = 2'd0,
      stackPointerPush = 2'd1,
      stackPointerPop  = 2'd2,
      stackPointerIll  = 2'd3
   } stackPointerOp_e;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: DEPTH x DATA_W, one synchronous write port and one
// asynchronous read port so a pop can register the top entry in one edge.
module stack_ram #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              wrEn,
   input  logic [ADDR_W-1:0] wrAddr,
   input  logic [DATA_W-1:0] wrData,
   input  logic [ADDR_W-1:0] rdAddr,
   output logic [DATA_W-1:0] rdData
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write the addressed entry on a granted push.
   // NOTE: storage has no reset; entries are only read below the stack
   // pointer, so they are always written before they are observed.
   always_ff @(posedge clock) begin
      if (wrEn) begin
         mem[wrAddr] <= wrData;
      end
   end

   assign rdData = mem[rdAddr];

endmodule

// File: rtl/stack_unit.sv
// Call/return and data stack serving memory-stage stack requests. Owns the
// stack pointer, the one-shot request arming, the full/empty flags, the
// registered pop result and the sticky error flag.
module stack_unit
   import stack_unit_pkg::*;
#(
   parameter int DATA_W = STACK_DATA_W,
   parameter int DEPTH  = STACK_DEPTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enMem,
   input  logic              sigStackMem,
   input  logic [1:0]        sigNewSP,
   input  logic              sigAddData,
   input  logic [DATA_W-1:0] returnAddr,
   input  logic [DATA_W-1:0] pushData,
   output logic [DATA_W-1:0] stackOut,
   output logic              fullFlag,
   output logic              emptyFlag,
   output logic              stackErr
);

   localparam int SP_W   = $clog2(DEPTH + 1);
   localparam int ADDR_W = $clog2(DEPTH);

   logic [SP_W-1:0]   sp, spNext;
   logic              armed, armedNext;
   logic [DATA_W-1:0] outNext;
   logic              errNext;
   logic              request, accept;
   logic              isFull, isEmpty;
   logic              wrEn;
   logic [DATA_W-1:0] wrData, rdData;
   logic [ADDR_W-1:0] wrAddr, rdAddr;
   stackPointerOp_e   op;

   assign request = enMem && sigStackMem;
   assign accept  = request && armed;
   assign op      = stackPointerOp_e'(sigNewSP);
   assign isFull  = (sp == SP_W'(DEPTH));
   assign isEmpty = (sp == '0);

   // The write index is sp itself; the top entry sits at sp-1.
   assign wrAddr = ADDR_W'(sp);
   assign rdAddr = ADDR_W'(sp - SP_W'(1));
   assign wrData = sigAddData ? returnAddr : pushData;

   stack_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clock  (clock),
      .wrEn   (wrEn),
      .wrAddr (wrAddr),
      .wrData (wrData),
      .rdAddr (rdAddr),
      .rdData (rdData)
   );

   // Decode the accepted request into next pointer, output, error and arming.
   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      spNext    = sp;
      outNext   = stackOut;
      errNext   = stackErr;
      wrEn      = 1'b0;
      // Any cycle with a request disarms (whether accepted or held); an idle
      // cycle re-arms, giving one operation per memory-stage visit.
      armedNext = !request;
      if (accept) begin
         case (op)
            stackPointerDef: ;
            stackPointerPush: begin
               if (isFull) begin
                  errNext = 1'b1;
               end else begin
                  wrEn   = 1'b1;
                  spNext = sp + SP_W'(1);
               end
            end
            stackPointerPop: begin
               if (isEmpty) begin
                  errNext = 1'b1;
               end else begin
                  outNext = rdData;
                  spNext  = sp - SP_W'(1);
               end
            end
            default: errNext = 1'b1;
         endcase
      end
   end

   // Register pointer, arming, pop result and sticky error; reset wins.
   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         sp       <= '0;
         armed    <= 1'b1;
         stackOut <= '0;
         stackErr <= 1'b0;
      end else begin
         sp       <= spNext;
         armed    <= armedNext;
         stackOut <= outNext;
         stackErr <= errNext;
      end
   end

   assign fullFlag  = isFull;
   assign emptyFlag = isEmpty;

endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware call/return and data stack answering the control unit's memory-stage stack requests. On CALL/PUSH it stores a return address or register value; on RET/POP it pops the top entry onto `stackOut`, which feeds the `pcStack` PC source and the write-back mux. It owns the stack pointer and generates the `fullFlag`/`emptyFlag` inputs the control unit uses to gate `sigNewSP`.

## Interface
- `DATA_W`, 16: width of a stack entry and of the return-address/data buses.
- `DEPTH`, 8: number of entries; any value ≥ 2. Pointer width is clog2(DEPTH+1).

- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `enMem`  in  1  memory-stage enable from the control unit.
- `sigStackMem`  in  1  stack access selected, not data memory.
- `sigNewSP`  in  2  operation code: `stackPointerDef`=0 (none), `stackPointerPush`=1, `stackPointerPop`=2. Code 3 is illegal.
- `sigAddData`  in  1  push source: 1 = `returnAddr` (CALL), 0 = `pushData` (PUSH).
- `returnAddr`  in  DATA_W  PC+1 from the fetch path.
- `pushData`  in  DATA_W  register-file read port B.
- `stackOut`  out  DATA_W  last popped value, registered.
- `fullFlag`  out  1  sp == DEPTH.
- `emptyFlag`  out  1  sp == 0.
- `stackErr`  out  1  sticky illegal-request indicator.

## Operation
- State:
  - `sp` (0..DEPTH): entry count and next-write index.
  - `armed`: 1-bit, set means a new request may be accepted.
  - `stackOut` register.
  - `stackErr` register.
  - Storage array of DEPTH × DATA_W.
- A request is present when `enMem && sigStackMem` is high. It is accepted on the first rising edge where it is present and `armed`=1.
- Accepting a request clears `armed`. `armed` sets again on any edge where no request is present.
- Result: exactly one stack operation per memory-stage visit, even if the control unit holds `sigNewSP` for several cycles.
- Push, accepted when not full:
  - mem[sp] <= (`sigAddData` ? `returnAddr` : `pushData`).
  - sp <= sp+1.
  - `stackOut` unchanged.
- Pop, accepted when not empty:
  - `stackOut` <= mem[sp-1].
  - sp <= sp-1.
  - The entry is not cleared.
- Code 0 accepted: no change; `armed` still clears.
- The following set `stackErr` and leave sp, mem and `stackOut` unchanged:
  - Push while full.
  - Pop while empty.
  - Code 3.
- The control unit normally prevents the first two cases by sending code 0 instead.
- `stackErr` clears only on reset.
- `fullFlag` and `emptyFlag` are decoded from the `sp` register alone. There is no combinational path from any input to any output.
- No wrap-around: sp saturates at 0 and DEPTH.

## Timing
- Reset values:
  - sp=0, so `emptyFlag`=1 and `fullFlag`=0.
  - `stackOut`=0.
  - `stackErr`=0.
  - `armed`=1.
  - Storage contents are not reset.
- Reset has priority over any request on the same edge. A request held across reset deassertion is accepted on the first edge after reset.
- Latency: for a request accepted at edge E, the new sp, flags, `stackOut` and `stackErr` are visible immediately after E. This means a POP result is valid during the following write-back cycle, and a RET target is valid during the following fetch cycle.
- Back-to-back operations need at least one edge without a request between them. An op-code change while the request is held gives no second operation.
- PUSH at sp=DEPTH-1 sets `fullFlag` after the edge. POP at sp=1 sets `emptyFlag` after the edge.

## Structure
- The `stackPointerDef`/`Push`/`Pop` codes are defined in the shared constants include already used by the control unit. They are not redefined locally.
- Sub-module `stack_ram`: DEPTH × DATA_W, one synchronous write port, one asynchronous read port, no reset.
- `stack_unit` holds the pointer, the arming logic, the flags, `stackOut` and `stackErr`.

## Test plan
All scenarios use DEPTH=8 and DATA_W=16.
- Reset, then idle: `emptyFlag`=1, `fullFlag`=0, `stackOut`=0, `stackErr`=0.
- CALL with `returnAddr`=0x0012 and `sigAddData`=1, then RET.
  - After the RET edge, `stackOut`=0x0012.
  - `emptyFlag`=1 again.
- PUSH with `pushData`=0xA5A5 and `sigNewSP`=1, with the request held for 3 cycles.
  - sp=1 only, not 3.
  - A subsequent POP yields 0xA5A5.
- Eight pushes of 0x0001..0x0008 give `fullFlag`=1.
  - A ninth push sets `stackErr`=1 and sp stays 8.
  - Eight pops then return 0x0008..0x0001 in order.
- From reset:
  - A pop gives `stackErr`=1 and `stackOut`=0.
  - Code 3 on a non-empty stack leaves sp and `stackOut` unchanged.
  - `reset` asserted on the same edge as a push leaves sp=0.
